sysbus_fabric: RTL
==================

# sysbus_fabric

Parametrised system bus fabric for the 6801-class CPU core: decodes the I/O window into N 32-byte peripheral slots, with the remaining space routed to external memory. Inserts wait states through the CPU `hold` input and returns the read data. Aggregates peripheral interrupts through a maskable, edge/level-configurable pending register. Sits between `cpu68` and all bus peripherals, replacing hand-written chip-select and data-mux logic in the top level.

## Interface
- `NSLOTS`, 8: peripheral slots; slot k is decoded at `IO_BASE + 32*k`; range 1..15.
- `IO_BASE`, 16'hE600: base of the I/O window; must be 32-byte aligned.
- `CTRL_SLOT`, 7: slot index occupied by the fabric's own registers; that slot's `slot_cs` is never asserted.
- `NIRQ`, 4: interrupt sources; range 1..8.
- `IRQ_EDGE`, 0: per-source mask; 1 means rising-edge latched, 0 means level.
- `EXT_WAIT`, 1: extra hold cycles for every external access; range 0..7.
- `TIMEOUT`, 15: maximum number of consecutive cycles with `slot_rdy` low before the access is forced to complete.

Ports (clock and reset first):
- `clk`, in, 1: the single clock for the block.
- `rst`, in, 1: reset, asynchronous and active-low.
- `vma`, in, 1: CPU valid memory address.
- `rw`, in, 1: CPU read (1) or write (0).
- `ad`, in, 16: CPU address.
- `cpu_do`, in, 8: CPU write data.
- `cpu_di`, out, 8: read data to the CPU.
- `hold`, out, 1: stalls the CPU.
- `irq`, out, 1: interrupt request to the CPU.
- `slot_cs`, out, NSLOTS: one-hot peripheral select, gated by `vma`.
- `slot_do`, in, 8*NSLOTS: peripheral read data; slot k occupies bits [8k+7:8k].
- `slot_rdy`, in, NSLOTS: peripheral ready; tie high for zero-wait peripherals.
- `ext_cs`, out, 1: external memory select, gated by `vma`.
- `ext_di`, in, 8: external read data.
- `irq_src`, in, NIRQ: peripheral interrupt lines, synchronous to `clk`.

## Operation
- Decode is combinational. `ad` in `[IO_BASE, IO_BASE+32*NSLOTS)` selects slot `(ad-IO_BASE)>>5`. All other addresses select external memory.
- Read mux: the selected slot's `slot_do`, the control registers, or `ext_di`.
  - An unselected slot, or a timed-out access, returns 8'hFF.
- Control registers sit at slot CTRL_SLOT, offsets 0..3. Any other offset reads 0 and ignores writes.
  - 0 `IRQ_PEND`: read returns pending bits; a write clears every bit written as 1.
  - 1 `IRQ_MASK`: read/write; 1 enables the source; resets to 0.
  - 2 `IRQ_VEC`: read-only; bit7 set when any source is pending and enabled, bits[2:0] hold the lowest-index such source.
  - 3 `BUS_ERR`: bit7 is the sticky timeout flag, bits[3:0] the slot that timed out. Any write clears it.
- Interrupt behaviour:
  - Edge sources set `pend` on a 0→1 transition of `irq_src` (one registered sample).
  - Level sources set `pend` whenever `irq_src` is 1. A clear is therefore overridden the same cycle while the source is still high; set wins over clear.
  - `irq` is registered: `|(pend & mask)`.
- Wait FSM states:
  - IDLE: on `vma` with a target that needs waiting (external with EXT_WAIT>0, or a slot with `slot_rdy`=0), go to WAIT, load `cnt`, and assert `hold` combinationally in the same cycle.
  - WAIT:
    - External access: count down from EXT_WAIT−1 and go to DONE at 0.
    - Slot access: go to DONE when `slot_rdy`=1, or when `cnt` reaches TIMEOUT. A timeout sets `BUS_ERR`.
  - DONE: `hold`=0 for exactly one cycle so the access completes; return to IDLE. A new access cannot re-arm WAIT until IDLE.
- Reset values: `hold`=0, `irq`=0, `pend`=0, `mask`=0, `BUS_ERR`=0, FSM in IDLE. `cpu_di`, `slot_cs` and `ext_cs` follow their inputs combinationally.

## Timing
- Zero-wait slot read: `cpu_di` is valid in the same cycle as `vma`. 0 added cycles.
- External access: `hold` is high for exactly EXT_WAIT cycles, then one completion cycle, so the access takes EXT_WAIT+1 cycles.
- Slot stretch: `hold` stays high until the cycle after `slot_rdy` is seen, capped at TIMEOUT cycles.
- Control register writes take effect at the clock edge ending the access.
- `irq` rises 2 cycles after an `irq_src` edge: one cycle to capture into `pend`, one to register `irq`.
- Reset asserted mid-WAIT: `hold` drops asynchronously, the FSM goes to IDLE, and `BUS_ERR` is not set.
- `rst` deassertion is synchronised by the instantiating top level.

## Structure
- Package `sysbus_pkg`: register offsets (`REG_PEND`, `REG_MASK`, `REG_VEC`, `REG_ERR`), the FSM state encoding, and the 32-byte slot size constant.
- Sub-module `irq_agg`: pending/mask/priority encoder. It is instantiated once; the wait FSM and decode stay in the top level.

## Test plan
- Read slot 2 (0xE640) with `slot_do[23:16]`=8'h5A and `slot_rdy` high: `cpu_di`=8'h5A, `hold` never asserted, `slot_cs`=8'b0000_0100.
- EXT_WAIT=3, read 0x1234: `hold` high for exactly 3 cycles, `ext_cs` held throughout, `cpu_di`=`ext_di` in the DONE cycle.
- Slot 4 with `slot_rdy` stuck low, TIMEOUT=15: `hold` drops after 15 cycles, `cpu_di`=8'hFF, a read of 0xE6E3 returns 8'h84.
- `IRQ_EDGE`=4'b0001, `mask`=4'hF, pulse `irq_src[0]` for one cycle: `irq`=1 two cycles later; `IRQ_VEC`=8'h80; writing 8'h01 to `IRQ_PEND` makes `irq`=0 on the next cycle.
- Level source 1 held high while 8'h02 is written to `IRQ_PEND`: the pending bit stays 1 and `irq` stays 1.
- `rst` pulsed low during an external WAIT: `hold`=0 immediately, `mask` reads 0 afterwards, and the next access starts a full EXT_WAIT count.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared constants and types for the system bus fabric: register map,
// slot geometry and wait-state FSM encoding.
package sysbus_pkg;

    localparam int SLOT_SIZE  = 32;
    localparam int SLOT_SHIFT = 5;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_VEC  = 2'd2;
    localparam logic [1:0] REG_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } wait_st_e;

    typedef struct packed {
        logic       io;
        logic       ctrl;
        logic [3:0] slot;
        logic [4:0] off;
    } dec_t;

endpackage

// File: rtl/sysbus_fabric_irq_agg.sv
// Interrupt aggregator: per-source edge/level capture into a pending
// register, enable mask, lowest-index priority vector and registered irq.
import sysbus_pkg::*;

module irq_agg #(
    parameter int              NIRQ     = 4,
    parameter logic [NIRQ-1:0] IRQ_EDGE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_src,
    input  logic            pend_wr,
    input  logic            mask_wr,
    input  logic [NIRQ-1:0] wdata,
    output logic [NIRQ-1:0] pend,
    output logic [NIRQ-1:0] mask,
    output logic [7:0]      vec,
    output logic            irq
);

    logic [NIRQ-1:0] src_q;
    logic [NIRQ-1:0] set;
    logic [NIRQ-1:0] clr;
    logic [NIRQ-1:0] act;

    assign set = (irq_src & ~src_q & IRQ_EDGE) | (irq_src & ~IRQ_EDGE);
    assign clr = pend_wr ? wdata : '0;
    assign act = pend & mask;

    // Set is applied after clear so a still-active level source wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= '0;
            pend  <= '0;
            mask  <= '0;
            irq   <= 1'b0;
        end else begin
            src_q <= irq_src;
            pend  <= (pend & ~clr) | set;
            if (mask_wr) mask <= wdata;
            irq   <= |act;
        end
    end

    always_comb begin
        vec = 8'h00;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (act[k]) vec[2:0] = 3'(k);
        end
        vec[7] = |act;
    end

endmodule

// File: rtl/sysbus_fabric.sv
// System bus fabric: I/O window decode, read mux, wait-state FSM driving
// the CPU hold line, bus-error capture and interrupt aggregation.
import sysbus_pkg::*;

module sysbus_fabric #(
    parameter int              NSLOTS    = 8,
    parameter logic [15:0]     IO_BASE   = 16'hE600,
    parameter int              CTRL_SLOT = 7,
    parameter int              NIRQ      = 4,
    parameter logic [NIRQ-1:0] IRQ_EDGE  = '0,
    parameter int              EXT_WAIT  = 1,
    parameter int              TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vma,
    input  logic                rw,
    input  logic [15:0]         ad,
    input  logic [7:0]          cpu_do,
    output logic [7:0]          cpu_di,
    output logic                hold,
    output logic                irq,
    output logic [NSLOTS-1:0]   slot_cs,
    input  logic [8*NSLOTS-1:0] slot_do,
    input  logic [NSLOTS-1:0]   slot_rdy,
    output logic                ext_cs,
    input  logic [7:0]          ext_di,
    input  logic [NIRQ-1:0]     irq_src
);

    localparam int CW = 8;

    dec_t            dec;
    logic [16:0]     off_full;
    logic [7:0]      sel_do;
    logic            sel_rdy;
    logic            ext_wait;
    logic            slot_wait;
    logic            start_wait;
    wait_st_e        st, st_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            tmo, tmo_d;
    logic            err_set;
    logic            err_flag;
    logic [3:0]      err_slot;
    logic            wr;
    logic [NIRQ-1:0] pend, mask;
    logic [7:0]      vec;
    logic [7:0]      ctrl_rd;
    logic            unused_wdata;

    assign off_full = {1'b0, ad} - {1'b0, IO_BASE};
    assign dec.io   = !off_full[16] && (off_full < 17'(SLOT_SIZE * NSLOTS));
    assign dec.slot = off_full[SLOT_SHIFT +: 4];
    assign dec.off  = off_full[SLOT_SHIFT-1:0];
    assign dec.ctrl = dec.io && (dec.slot == 4'(CTRL_SLOT));

    for (genvar k = 0; k < NSLOTS; k++) begin : g_cs
        assign slot_cs[k] = vma && dec.io && (dec.slot == 4'(k)) && (k != CTRL_SLOT);
    end
    assign ext_cs = vma && !dec.io;

    always_comb begin
        sel_do  = 8'hFF;
        sel_rdy = 1'b1;
        for (int k = 0; k < NSLOTS; k++) begin
            if (dec.slot == 4'(k)) begin
                sel_do  = slot_do[8*k +: 8];
                sel_rdy = slot_rdy[k];
            end
        end
    end

    assign ext_wait   = (EXT_WAIT > 0) && !dec.io;
    assign slot_wait  = vma && dec.io && !dec.ctrl && !sel_rdy;
    assign start_wait = (vma && ext_wait) || slot_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= ST_IDLE;
            cnt      <= '0;
            tmo      <= 1'b0;
            err_flag <= 1'b0;
            err_slot <= '0;
        end else begin
            st  <= st_d;
            cnt <= cnt_d;
            tmo <= tmo_d;
            if (err_set) begin
                err_flag <= 1'b1;
                err_slot <= dec.slot;
            end else if (wr && dec.off == {3'b000, REG_ERR}) begin
                err_flag <= 1'b0;
                err_slot <= '0;
            end
        end
    end

    // The CPU holds ad stable while stalled, so live decode steers WAIT.
    always_comb begin
        st_d    = st;
        cnt_d   = cnt;
        tmo_d   = 1'b0;
        err_set = 1'b0;
        case (st)
            ST_IDLE: begin
                if (vma && ext_wait) begin
                    cnt_d = CW'(EXT_WAIT - 1);
                    st_d  = (EXT_WAIT == 1) ? ST_DONE : ST_WAIT;
                end else if (slot_wait) begin
                    cnt_d = CW'(1);
                    if (TIMEOUT <= 1) begin
                        st_d    = ST_DONE;
                        tmo_d   = 1'b1;
                        err_set = 1'b1;
                    end else begin
                        st_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!dec.io) begin
                    cnt_d = cnt - CW'(1);
                    if (cnt == CW'(1)) st_d = ST_DONE;
                end else if (sel_rdy) begin
                    st_d = ST_DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        st_d    = ST_DONE;
                        tmo_d   = 1'b1;
                        err_set = 1'b1;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold = 1'b0;
        if (rst) begin
            case (st)
                ST_IDLE: hold = start_wait;
                ST_WAIT: hold = 1'b1;
                default: hold = 1'b0;
            endcase
        end
    end

    assign wr           = vma && !rw && dec.ctrl && !hold;
    assign unused_wdata = ^cpu_do;

    irq_agg #(
        .NIRQ     (NIRQ),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_irq (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .pend_wr (wr && dec.off == {3'b000, REG_PEND}),
        .mask_wr (wr && dec.off == {3'b000, REG_MASK}),
        .wdata   (cpu_do[NIRQ-1:0]),
        .pend    (pend),
        .mask    (mask),
        .vec     (vec),
        .irq     (irq)
    );

    always_comb begin
        ctrl_rd = 8'h00;
        if (dec.off[4:2] == 3'b000) begin
            case (dec.off[1:0])
                REG_PEND: ctrl_rd = 8'(pend);
                REG_MASK: ctrl_rd = 8'(mask);
                REG_VEC:  ctrl_rd = vec;
                default:  ctrl_rd = {err_flag, 3'b000, err_slot};
            endcase
        end
    end

    always_comb begin
        if (dec.ctrl)                cpu_di = ctrl_rd;
        else if (!dec.io)            cpu_di = ext_di;
        else if (st == ST_DONE && tmo) cpu_di = 8'hFF;
        else                         cpu_di = sel_do;
    end

endmodule
